// File: rtl/display_scan_control_if.sv
// display_scan_control_if: scan controller bus (enable/load/message/blink in; ack/tick/anodes/digit out)
interface display_scan_control_if;
    logic        enable;
    logic [15:0] message_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  anodes;
    logic [3:0]  digit;
    modport master (
        output enable, message_in, load, blink_mask,
        input  load_ack, frame_tick, anodes, digit
    );
    modport slave (
        input  enable, message_in, load, blink_mask,
        output load_ack, frame_tick, anodes, digit
    );
endinterface

// File: rtl/display_scan_control.sv
// display_scan_control: 4-digit common-anode scanner with guard blanking, frame-boundary message commit and per-digit blink; ports clock, reset, bus(slave)
module display_scan_control #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 250
) (
    input logic                   clock,
    input logic                   reset,
    display_scan_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [PW-1:0] pre, pre_n;
    logic [GW-1:0] grd, grd_n;
    logic [15:0]   active, active_n, shadow, shadow_n;
    logic          pending, pending_n, hidden, hidden_n;
    logic [FW-1:0] frame, frame_n;
    logic [3:0]    anodes_n, digit_n;
    logic          load_ack_n, wrap, tick, frame_last;
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            pre            <= '0;
            grd            <= '0;
            active         <= '1;
            shadow         <= '1;
            pending        <= 1'b0;
            hidden         <= 1'b0;
            frame          <= '0;
            bus.anodes     <= '1;
            bus.digit      <= '1;
            bus.load_ack   <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            pre            <= pre_n;
            grd            <= grd_n;
            active         <= active_n;
            shadow         <= shadow_n;
            pending        <= pending_n;
            hidden         <= hidden_n;
            frame          <= frame_n;
            bus.anodes     <= anodes_n;
            bus.digit      <= digit_n;
            bus.load_ack   <= load_ack_n;
            bus.frame_tick <= tick;
        end
    end
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        pre_n      = pre;
        grd_n      = grd;
        anodes_n   = bus.anodes;
        digit_n    = bus.digit;
        wrap       = state == DRIVE && pre == PW'(REFRESH_DIV - 1);
        tick       = bus.enable && wrap && idx == 2'd3;
        frame_last = frame == FW'(BLINK_FRAMES - 1);
        if (!bus.enable) begin
            state_n  = IDLE;
            idx_n    = '0;
            pre_n    = '0;
            grd_n    = '0;
            anodes_n = '1;
            digit_n  = '1;
        end else if (state == IDLE) begin
            state_n = BLANK;
            grd_n   = '0;
        end else if (state == BLANK) begin
            if (grd == GW'(GUARD_CYCLES - 1)) begin
                state_n  = DRIVE;
                pre_n    = '0;
                anodes_n = ~(4'b0001 << idx);
                digit_n  = hidden && bus.blink_mask[idx] ? 4'hF : active[{idx, 2'b00} +: 4];
            end else begin
                grd_n = grd + 1'b1;
            end
        end else if (wrap) begin
            state_n  = BLANK;
            idx_n    = idx + 2'd1;
            grd_n    = '0;
            anodes_n = '1;
            digit_n  = '1;
        end else begin
            pre_n = pre + 1'b1;
        end
        shadow_n   = bus.load ? bus.message_in : shadow;
        pending_n  = pending || bus.load;
        active_n   = active;
        load_ack_n = 1'b0;
        if ((tick && (pending || bus.load)) || (!bus.enable && pending)) begin
            active_n   = bus.load ? bus.message_in : shadow;
            pending_n  = 1'b0;
            load_ack_n = 1'b1;
        end
        frame_n  = frame;
        hidden_n = hidden;
        if (tick && BLINK_FRAMES > 0) begin
            frame_n  = frame_last ? '0 : frame + 1'b1;
            hidden_n = frame_last ? !hidden : hidden;
        end
    end
endmodule

// File: tb/tb_display_scan_control.sv
// tb_display_scan_control: directed plan steps plus random traffic checked every cycle against an arithmetic scan model
module tb_display_scan_control;
    localparam int RD = 4;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam int P  = RD + G;
    localparam int F  = 4 * P;
    logic clock = 1'b0;
    logic reset = 1'b1;
    display_scan_control_if bus ();
    display_scan_control #(.REFRESH_DIV(RD), .GUARD_CYCLES(G), .BLINK_FRAMES(BF)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    int n_cmp = 0;
    int n_bad = 0;
    int s = -1;
    logic [15:0] m_act = '1, m_sh = '1;
    bit m_pend = 0, m_hid = 0, m_ack = 0, m_tick = 0;
    int m_fc = 0;
    logic [3:0] m_an = '1, m_dg = '1;
    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, o, e, $time);
        end
    endtask
    task automatic step();
        int idx;
        bit tick;
        @(posedge clock);
        if (reset) begin
            s = -1; m_act = '1; m_sh = '1; m_pend = 0; m_hid = 0; m_fc = 0;
            m_an = '1; m_dg = '1; m_ack = 0; m_tick = 0;
        end else begin
            tick = bus.enable && s >= 0 && (s + 1) % F == 0;
            s = bus.enable ? s + 1 : -1;
            if (s < 0 || s % P < G) begin
                m_an = '1;
                m_dg = '1;
            end else begin
                idx = (s % F) / P;
                m_an = ~(4'b0001 << idx);
                if (s % P == G) m_dg = (m_hid && bus.blink_mask[idx]) ? 4'hF : m_act[idx*4 +: 4];
            end
            m_tick = tick;
            m_ack = 0;
            if ((tick && (m_pend || bus.load)) || (!bus.enable && m_pend)) begin
                m_act = bus.load ? bus.message_in : m_sh;
                if (bus.load) m_sh = bus.message_in;
                m_pend = 0;
                m_ack = 1;
            end else if (bus.load) begin
                m_sh = bus.message_in;
                m_pend = 1;
            end
            if (tick && BF > 0) begin
                if (m_fc == BF - 1) begin
                    m_fc = 0;
                    m_hid = !m_hid;
                end else m_fc++;
            end
        end
        #1;
        chk("anodes", 16'(bus.anodes), 16'(m_an));
        chk("digit", 16'(bus.digit), 16'(m_dg));
        chk("load_ack", 16'(bus.load_ack), 16'(m_ack));
        chk("frame_tick", 16'(bus.frame_tick), 16'(m_tick));
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic load_once(input logic [15:0] v);
        bus.load = 1'b1;
        bus.message_in = v;
        step();
        bus.load = 1'b0;
    endtask
    task automatic wait_digit(input int d);
        for (int i = 0; i < 2 * F && !(s >= 0 && (s % F) / P == d && s % P == G); i++) step();
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.load = 1'b0;
        bus.message_in = '0;
        bus.blink_mask = '0;
        run(3);
        chk("rst_anodes", 16'(bus.anodes), 16'hF);
        chk("rst_digit", 16'(bus.digit), 16'hF);
        reset = 1'b0;
        load_once(16'h3210);
        step();
        chk("ack_disabled", 16'(bus.load_ack), 16'h1);
        bus.enable = 1'b1;
        run(2 * F + 3);
        wait_digit(1);
        load_once(16'h0066);
        run(F + 4);
        wait_digit(0);
        load_once(16'h1111);
        run(5);
        load_once(16'h4444);
        run(F + 5);
        wait_digit(0);
        load_once(16'h3210);
        bus.blink_mask = 4'b0001;
        run(6 * F + 2);
        bus.blink_mask = '0;
        wait_digit(2);
        step();
        bus.enable = 1'b0;
        step();
        chk("dis_anodes", 16'(bus.anodes), 16'hF);
        chk("dis_tick", 16'(bus.frame_tick), 16'h0);
        bus.enable = 1'b1;
        run(F + 2);
        wait_digit(1);
        load_once(16'h9876);
        reset = 1'b1;
        step();
        chk("rst2_digit", 16'(bus.digit), 16'hF);
        reset = 1'b0;
        run(2 * F + 3);
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(299) == 0);
            if (bus.enable) bus.enable = ($urandom_range(59) != 0);
            else bus.enable = ($urandom_range(3) == 0);
            bus.load = ($urandom_range(9) == 0);
            bus.message_in = 16'($urandom);
            if ($urandom_range(19) == 0) bus.blink_mask = 4'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/display_scan_control.md
Name: display_scan_control

Overview:
- Upstream stage of the 7-segment cathode decoder.
- Holds a 4-position message of 4-bit display codes and time-multiplexes them onto a 4-digit common-anode display.
- Each cycle it drives one active-low anode and presents that position's code on Digit, which feeds the cathode decoder.
- Also provides double-buffered message loading at frame boundaries, per-digit blinking, and an anti-ghosting blank interval between digits.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit is driven (≥2).
GUARD_CYCLES, 2, cycles all anodes are off between digits (≥1).
BLINK_FRAMES, 250, frames per blink half-period; 0 disables blinking.

Ports:
Clock  in  1  system clock, all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
Enable  in  1  scan enable.
MessageIn  in  16  four codes; [3:0] position 0 (rightmost) … [15:12] position 3.
Load  in  1  request to latch MessageIn.
BlinkMask  in  4  bit i=1: position i blinks.
LoadAck  out  1  one-cycle pulse when the new message becomes active.
FrameTick  out  1  one-cycle pulse at the end of each full 4-digit scan.
Anodes  out  4  active-low one-hot digit select.
Digit  out  4  code to cathode decoder; 4'hF = blank.

Behaviour:
- All outputs registered.
- Reset: Anodes=4'b1111, Digit=4'hF, LoadAck=0, FrameTick=0; state IDLE; Index=0; prescaler=0; guard counter=0; active=shadow=16'hFFFF; pending=0; blink phase=visible; frame counter=0.
- Codes pass through unmodified, including unassigned codes 7..14; the decoder blanks those.
- FSM states:
  - IDLE: Anodes=1111, Digit=F. If Enable=1, go to BLANK with guard counter=0.
  - BLANK: Anodes=1111, Digit=F. Guard counter counts 0..GUARD_CYCLES-1. On the last count, go to DRIVE. In that same edge, load Anodes=~(1<<Index) and Digit=code(Index), and clear the prescaler.
  - DRIVE: prescaler counts 0..REFRESH_DIV-1. At terminal count:
    - Index <= Index+1 mod 4; state <= BLANK; Anodes <= 1111; Digit <= F.
    - If the old Index was 3, FrameTick=1 for this one cycle.
- Timing: digit period = REFRESH_DIV+GUARD_CYCLES; frame = 4×digit period.
- code(i) = active[4i+3:4i], except Digit=4'hF when blink phase=hidden and BlinkMask[i]=1. During a hidden blink phase the anode is still driven.
- BlinkMask is sampled when a digit enters DRIVE and is held for that digit.
- Load handling:
  - Load=1 writes MessageIn to shadow and sets pending. Repeated Loads overwrite; the last wins.
  - Commit (active<=shadow, pending<=0, LoadAck=1 for one cycle) happens on the FrameTick edge, so LoadAck coincides with FrameTick.
  - Load on the commit edge: MessageIn goes directly to active, LoadAck pulses, pending=0.
  - While Enable=0, pending commits on the next edge, so LoadAck follows Load by one cycle.
- Enable=0 in any state: next edge → IDLE, Anodes=1111, Digit=F, Index=0, prescaler=0, guard counter=0.
  - No FrameTick is generated.
  - active, shadow, blink phase and frame counter are preserved.
- Blink: the frame counter increments on each FrameTick. When it reaches BLINK_FRAMES-1 it clears and the phase toggles. With BLINK_FRAMES=0 the phase stays visible.
- Reset has priority over all inputs. Reset mid-operation discards pending and shadow.

Test Plan (REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=2):
1. After reset, with Enable=0, Load=1, MessageIn=16'h3210 → LoadAck=1 next cycle. Raise Enable → Anodes: 1111 for 1 cycle, then 1110 with Digit=0 for 4 cycles, 1111 for 1 cycle, 1101/1, 1011/2, 0111/3. FrameTick every 20 cycles.
2. Scanning 16'h3210; Load 16'h0066 during digit 1 → digits 1–3 of the current frame show 1,2,3. LoadAck and FrameTick are high in the same cycle. The next frame shows 6,6,0,0 on positions 0–3.
3. Load 16'h1111, then Load 16'h4444 within one frame → exactly one LoadAck at frame end; the next frame shows 4 on all positions.
4. BlinkMask=4'b0001, message 16'h3210 → position 0 shows Digit=0 in frames 0–1, 4'hF in frames 2–3, 0 in frames 4–5. Positions 1–3 are never blanked; the anode pattern is unchanged.
5. Enable dropped during digit 2 DRIVE → next cycle Anodes=1111, Digit=F, no FrameTick. Re-enable → 1 blank cycle, then Anodes=1110 with position 0's code.
6. Reset asserted during DRIVE with a Load pending → next cycle all outputs at reset values. After re-enable with no Load, Digit=F on all positions, and no LoadAck occurs at the first FrameTick.
